direct_cache: RTL and testbench

Direct-mapped, write-back cache of 256 lines × 4 sixteen-bit words, with an internal 8192 × 16-bit backing memory (instance `mymemory`, array `mem`). An external controller drives the mode bits `comp`/`write`:

- Compare modes handle normal lookups and writes.
- Access modes let the controller inspect a victim line and fill a line.

The block sits between a 16-bit processor datapath and main storage in the memory-hierarchy exercises.

---
 rtl/direct_cache.sv | 163 ++++++++++++++++
 tb/tb_direct_cache.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/direct_cache.sv
// rtl/direct_cache.sv - direct-mapped write-back cache, 256 lines x 4 words, with backing memory

module direct_cache_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [10:0] wr_line,
  input  logic [63:0] wr_data,
  input  logic [10:0] rd_line,
  output logic [63:0] rd_data
);

  logic [15:0] mem [0:8191];

  // Whole-line combinational read; a fill sees contents from before this edge's write-back
  always_comb begin
    rd_data = {mem[{rd_line, 2'd3}], mem[{rd_line, 2'd2}],
               mem[{rd_line, 2'd1}], mem[{rd_line, 2'd0}]};
  end

  // Whole-line write-back of an evicted dirty line
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_line, 2'd0}] <= wr_data[15:0];
      mem[{wr_line, 2'd1}] <= wr_data[31:16];
      mem[{wr_line, 2'd2}] <= wr_data[47:32];
      mem[{wr_line, 2'd3}] <= wr_data[63:48];
    end
  end

endmodule

module direct_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [12:0] address,
  input  logic        comp,
  input  logic        write,
  input  logic [4:0]  t_in,
  input  logic [15:0] d_in,
  input  logic        valid_in,
  output logic        hit,
  output logic        dirt,
  output logic [4:0]  t_out,
  output logic [15:0] d_out,
  output logic        valid
);

  // Valid/dirty are the only state cleared by reset; tags and data keep stale contents
  logic [255:0] valid_q, valid_d;
  logic [255:0] dirty_q, dirty_d;
  logic [4:0]   tag_q  [0:255];
  logic [63:0]  data_q [0:255];

  logic [7:0]  idx;
  logic [1:0]  word;
  logic        line_valid;
  logic        line_dirty;
  logic [4:0]  line_tag;
  logic [63:0] line_data;
  logic [15:0] word_data;
  logic        tag_match;

  logic        line_we;
  logic [4:0]  tag_d;
  logic [63:0] line_data_d;
  logic        wb_we;
  logic [63:0] fill_data;

  assign idx  = address[9:2];
  assign word = address[1:0];

  direct_cache_mem mymemory (
    .clk     (clk),
    .we      (wb_we & ~rst),
    .wr_line ({line_tag[2:0], idx}),
    .wr_data (line_data),
    .rd_line (address[12:2]),
    .rd_data (fill_data)
  );

  // Look up the indexed line and select the addressed word
  always_comb begin
    line_valid = valid_q[idx];
    line_dirty = dirty_q[idx];
    line_tag   = tag_q[idx];
    line_data  = data_q[idx];
    tag_match  = line_valid & (line_tag == t_in);
    case (word)
      2'd0:    word_data = line_data[15:0];
      2'd1:    word_data = line_data[31:16];
      2'd2:    word_data = line_data[47:32];
      default: word_data = line_data[63:48];
    endcase
  end

  // Outputs are forced low when disabled; status bits are masked while reset is held
  always_comb begin
    hit   = 1'b0;
    dirt  = 1'b0;
    valid = 1'b0;
    t_out = 5'd0;
    d_out = 16'd0;
    if (en) begin
      hit   = comp & tag_match & ~rst;
      dirt  = line_dirty & ~rst;
      valid = line_valid & ~rst;
      t_out = line_tag;
      d_out = word_data;
    end
  end

  // Next line contents for compare-write hits and access-write fills
  always_comb begin
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    line_we     = 1'b0;
    wb_we       = 1'b0;
    tag_d       = line_tag;
    line_data_d = line_data;
    if (en && write) begin
      if (comp) begin
        if (tag_match) begin
          line_we      = 1'b1;
          dirty_d[idx] = 1'b1;
          case (word)
            2'd0:    line_data_d[15:0]  = d_in;
            2'd1:    line_data_d[31:16] = d_in;
            2'd2:    line_data_d[47:32] = d_in;
            default: line_data_d[63:48] = d_in;
          endcase
        end
      end else begin
        line_we      = 1'b1;
        wb_we        = line_valid & line_dirty;
        tag_d        = t_in;
        line_data_d  = fill_data;
        valid_d[idx] = valid_in;
        dirty_d[idx] = 1'b0;
      end
    end
  end

  // Status bits: cleared asynchronously for all lines at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage; a reset held across the edge cancels the update
  always_ff @(posedge clk) begin
    if (line_we && !rst) begin
      tag_q[idx]  <= tag_d;
      data_q[idx] <= line_data_d;
    end
  end

endmodule

// File: tb/tb_direct_cache.sv
// tb/tb_direct_cache.sv - randomized self-checking bench for direct_cache

module tb_direct_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [12:0] address;
  logic        comp;
  logic        write;
  logic [4:0]  t_in;
  logic [15:0] d_in;
  logic        valid_in;
  logic        hit;
  logic        dirt;
  logic [4:0]  t_out;
  logic [15:0] d_out;
  logic        valid;

  direct_cache dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .address  (address),
    .comp     (comp),
    .write    (write),
    .t_in     (t_in),
    .d_in     (d_in),
    .valid_in (valid_in),
    .hit      (hit),
    .dirt     (dirt),
    .t_out    (t_out),
    .d_out    (d_out),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  // Reference model: per-line state plus knowledge flags for never-written contents
  bit          m_valid [256];
  bit          m_dirty [256];
  bit          m_tagk  [256];
  logic [4:0]  m_tag   [256];
  logic [15:0] m_data  [256][4];
  bit          m_dk    [256][4];
  logic [15:0] m_mem   [8192];
  bit          m_mk    [8192];

  int passed = 0;
  int total  = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_update();
    int i, w, src, dst;
    logic [15:0] td [4];
    bit          tk [4];
    i   = int'(address[9:2]);
    w   = int'(address[1:0]);
    src = int'(address[12:2]) * 4;
    if (comp && write) begin
      if (m_valid[i] && m_tag[i] == t_in) begin
        m_data[i][w] = d_in;
        m_dk[i][w]   = 1'b1;
        m_dirty[i]   = 1'b1;
      end
    end else if (!comp && write) begin
      for (int k = 0; k < 4; k++) begin
        td[k] = m_mem[src + k];
        tk[k] = m_mk[src + k];
      end
      if (m_valid[i] && m_dirty[i]) begin
        dst = (int'(m_tag[i][2:0]) * 256 + i) * 4;
        for (int k = 0; k < 4; k++) begin
          m_mem[dst + k] = m_data[i][k];
          m_mk[dst + k]  = m_dk[i][k];
        end
      end
      for (int k = 0; k < 4; k++) begin
        m_data[i][k] = td[k];
        m_dk[i][k]   = tk[k];
      end
      m_tag[i]   = t_in;
      m_tagk[i]  = 1'b1;
      m_valid[i] = valid_in;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (en && !rst) model_update();
    #1;
  endtask

  task automatic set_in(input logic c, input logic wr, input logic [12:0] a,
                        input logic [4:0] t, input logic [15:0] d, input logic v);
    comp = c; write = wr; address = a; t_in = t; d_in = d; valid_in = v;
  endtask

  task automatic async_rst();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_valid", valid, 0);
    chk("async_dirt", dirt, 0);
    step();
    rst = 1'b0;
  endtask

  // Every cycle: outputs against the model for the current inputs
  always @(negedge clk) begin : compare_p
    int i, w;
    if (chk_on) begin
      i = int'(address[9:2]);
      w = int'(address[1:0]);
      if (!en) begin
        chk("off_hit", hit, 0);
        chk("off_dirt", dirt, 0);
        chk("off_valid", valid, 0);
        chk("off_t_out", t_out, 0);
        chk("off_d_out", d_out, 0);
      end else begin
        chk("hit", hit, (!rst && comp && m_valid[i] && m_tag[i] == t_in) ? 1 : 0);
        chk("valid", valid, (!rst && m_valid[i]) ? 1 : 0);
        chk("dirt", dirt, (!rst && m_dirty[i]) ? 1 : 0);
        if (m_tagk[i]) chk("t_out", t_out, m_tag[i]);
        if (m_dk[i][w]) chk("d_out", d_out, m_data[i][w]);
      end
    end
  end

  initial begin
    int idx, hi, wd;
    for (int i = 0; i < 256; i++) begin
      m_tagk[i] = 1'b0;
      for (int k = 0; k < 4; k++) m_dk[i][k] = 1'b0;
    end
    for (int i = 0; i < 8192; i++) m_mk[i] = 1'b0;
    model_reset();
    rst = 1'b1;
    en  = 1'b0;
    set_in(1'b0, 1'b0, 13'h0, 5'h0, 16'h0, 1'b0);
    repeat (2) step();
    rst    = 1'b0;
    chk_on = 1'b1;
    en     = 1'b1;

    set_in(1'b1, 1'b0, 13'h000F, 5'h00, 16'h0, 1'b0);
    #1;
    chk("reset_hit", hit, 0);
    chk("reset_valid", valid, 0);
    chk("reset_dirt", dirt, 0);

    // Build mem[12..15] = 1111..4444 and mem[1036..1039] = A000..A003 via write-backs
    set_in(1'b0, 1'b1, 13'h000C, 5'h00, 16'h0, 1'b1); step();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 1'b1, 13'(12 + k), 5'h00, 16'(16'h1111 * (k + 1)), 1'b0); step();
    end
    set_in(1'b0, 1'b1, 13'h040C, 5'h01, 16'h0, 1'b1); step();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 1'b1, 13'(13'h040C + k), 5'h01, 16'(16'hA000 + k), 1'b0); step();
    end
    set_in(1'b0, 1'b1, 13'h000F, 5'h00, 16'h0, 1'b1); step();

    set_in(1'b1, 1'b0, 13'h000F, 5'h00, 16'h0, 1'b0);
    #1;
    chk("fill_hit", hit, 1);
    chk("fill_d_out", d_out, 16'h4444);
    chk("fill_t_out", t_out, 5'h00);
    chk("fill_dirt", dirt, 0);

    set_in(1'b1, 1'b1, 13'h000D, 5'h00, 16'hBEEF, 1'b0); step();
    set_in(1'b1, 1'b0, 13'h000D, 5'h00, 16'h0, 1'b0);
    #1;
    chk("cw_hit", hit, 1);
    chk("cw_d_out", d_out, 16'hBEEF);
    chk("cw_dirt", dirt, 1);
    t_in = 5'h01;
    #1;
    chk("cw_tag_miss", hit, 0);

    set_in(1'b0, 1'b1, 13'h040D, 5'h01, 16'h0, 1'b1); step();
    set_in(1'b0, 1'b0, 13'h040D, 5'h01, 16'h0, 1'b0);
    #1;
    chk("wb_mem13", dut.mymemory.mem[13], 16'hBEEF);
    chk("evict_t_out", t_out, 5'h01);
    chk("evict_dirt", dirt, 0);
    chk("evict_hit", hit, 0);
    chk("evict_d_out", d_out, 16'hA001);

    en = 1'b0;
    set_in(1'b1, 1'b1, 13'h040D, 5'h01, 16'h1234, 1'b0);
    #1;
    chk("en0_hit", hit, 0);
    chk("en0_d_out", d_out, 0);
    chk("en0_valid", valid, 0);
    step();
    en = 1'b1;
    set_in(1'b1, 1'b0, 13'h040D, 5'h01, 16'h0, 1'b0);
    #1;
    chk("en1_hit", hit, 1);
    chk("en1_d_out", d_out, 16'hA001);
    chk("en1_dirt", dirt, 0);

    async_rst();
    set_in(1'b1, 1'b0, 13'h040D, 5'h01, 16'h0, 1'b0);
    #1;
    chk("post_rst_hit", hit, 0);
    step();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) == 0) async_rst();
      en   = ($urandom_range(9) != 0);
      idx  = int'($urandom_range(7));
      hi   = int'($urandom_range(7));
      wd   = int'($urandom_range(3));
      comp = 1'($urandom_range(1));
      write = 1'($urandom_range(1));
      address = 13'((hi << 10) | (idx << 2) | wd);
      if ($urandom_range(1) == 1 && m_tagk[idx]) t_in = m_tag[idx];
      else t_in = 5'($urandom_range(31));
      d_in     = 16'($urandom);
      valid_in = ($urandom_range(4) != 0);
      step();
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
